// File: rtl/smsdac_pkg.sv
// smsdac_pkg: shared constants, types and helpers for the tree-structured
// mismatch-shaping encoder (mode codes, dither LFSR taps, node split math).
package smsdac_pkg;

    // Shaping mode codes; 2'd3 behaves exactly like MODE_SHAPE1.
    localparam logic [1:0] MODE_FIXED      = 2'd0;
    localparam logic [1:0] MODE_SHAPE1     = 2'd1;
    localparam logic [1:0] MODE_RAND       = 2'd2;
    localparam logic [1:0] MODE_SHAPE1_ALT = 2'd3;

    // 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11.
    // With a right shift the feedback taps land on bits 0, 2, 3 and 5.
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Working width of the split helper; tree depth must stay at or below 15.
    localparam int SPLIT_W = 16;

    // Split sign applied at a node: top = (x+s)/2, bottom = (x-s)/2.
    typedef enum logic [1:0] {
        SIGN_ZERO = 2'd0,
        SIGN_POS  = 2'd1,
        SIGN_NEG  = 2'd2
    } sign_e;

    typedef struct packed {
        logic [SPLIT_W-1:0] top;
        logic [SPLIT_W-1:0] bottom;
    } split_t;

    // Split x into its two halves. For odd x the extra unit goes to the
    // top child when s is positive and to the bottom child when negative;
    // even x is only ever split with SIGN_ZERO.
    function automatic split_t split_node(input logic [SPLIT_W-1:0] x,
                                          input sign_e s);
        split_t             r;
        logic [SPLIT_W-1:0] half;
        half     = x >> 1;
        r.top    = half + SPLIT_W'(s == SIGN_POS);
        r.bottom = half + SPLIT_W'(s == SIGN_NEG);
        return r;
    endfunction

    // One LFSR advance: feedback enters at the MSB, register shifts right.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {^(l & LFSR_TAPS), l[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/smsdac_switch_block.sv
// smsdac_switch_block: one node of the encoder tree. Splits an input count
// over 2^K elements into top/bottom halves, choosing where an odd unit goes
// from the shaping mode, its own toggle state, or a dither bit.
module smsdac_switch_block
    import smsdac_pkg::*;
#(
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic         rnd,
    input  logic [K:0]   x,
    output logic [K-1:0] top,
    output logic [K-1:0] bottom
);

    logic   state;
    sign_e  sgn;
    split_t sp;
    logic   unused_split_bits;

    // Choose the split sign; only odd inputs carry a nonzero sign.
    always_comb begin
        sgn = SIGN_ZERO;
        if (x[0]) begin
            case (mode)
                MODE_FIXED: sgn = SIGN_POS;
                MODE_RAND:  sgn = rnd ? SIGN_POS : SIGN_NEG;
                default:    sgn = state ? SIGN_NEG : SIGN_POS;
            endcase
        end
    end

    // Apply the split; halves of a (K+1)-bit count always fit in K bits.
    always_comb begin
        sp     = split_node(SPLIT_W'(x), sgn);
        top    = sp.top[K-1:0];
        bottom = sp.bottom[K-1:0];
    end

    assign unused_split_bits = ^{sp.top[SPLIT_W-1:K], sp.bottom[SPLIT_W-1:K]};

    // First-order shaping state: flips each time an accepted odd input
    // is split in a shaping mode, so odd units alternate top/bottom.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= 1'b0;
        end else if (en && x[0] &&
                     (mode == MODE_SHAPE1 || mode == MODE_SHAPE1_ALT)) begin
            state <= ~state;
        end
    end

endmodule

// File: rtl/smsdac_tree_encoder.sv
// smsdac_tree_encoder: converts a sampled code (0..2^DEPTH, saturating) into
// 2^DEPTH registered unit-element enables through a binary tree of switch
// blocks. Owns input saturation, the dither LFSR and the output register.
// Handshake: a sample is taken on every rising edge where sample_valid is
// high (no backpressure); the matching elem appears one edge later with a
// single-cycle elem_valid pulse, and elem holds its value otherwise.
module smsdac_tree_encoder
    import smsdac_pkg::*;
#(
    parameter int          DEPTH     = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         NE        = 1 << DEPTH,
    localparam int         CW        = DEPTH + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid,
    input  logic [CW-1:0] code,
    input  logic [1:0]    mode,
    output logic [NE-1:0] elem,
    output logic          elem_valid
);

    // Bit offset of tree level l in the flat bus. Level l holds 2^l counts,
    // each (DEPTH-l+1) bits wide; level DEPTH is the 1-bit leaf level.
    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int m = 0; m < l; m++) begin
            o += (1 << m) * (DEPTH - m + 1);
        end
        return o;
    endfunction

    localparam int BUS_W    = lvl_off(DEPTH + 1);
    localparam int LEAF_OFF = lvl_off(DEPTH);

    logic [BUS_W-1:0]  tree_bus;
    logic [CW-1:0]     code_sat;
    logic [NE-1:0]     leaf_elem;
    logic [LFSR_W-1:0] lfsr;

    // Codes above the element count clamp to "all elements on".
    always_comb begin
        code_sat = (code > CW'(NE)) ? CW'(NE) : code;
    end

    assign tree_bus[CW-1:0] = code_sat;

    // Tree nodes in heap order: node (lvl, j) has heap index 2^lvl-1+j;
    // its top child is (lvl+1, 2j) and bottom child (lvl+1, 2j+1).
    for (genvar lvl = 0; lvl < DEPTH; lvl++) begin : g_lvl
        for (genvar j = 0; j < (1 << lvl); j++) begin : g_node
            localparam int K     = DEPTH - lvl;
            localparam int X_OFF = lvl_off(lvl) + j * (K + 1);
            localparam int T_OFF = lvl_off(lvl + 1) + (2 * j) * K;
            localparam int B_OFF = T_OFF + K;
            localparam int HEAP  = (1 << lvl) - 1 + j;

            smsdac_switch_block #(
                .K(K)
            ) u_node (
                .clk    (clk),
                .rst_n  (rst_n),
                .en     (sample_valid),
                .mode   (mode),
                .rnd    (lfsr[HEAP % LFSR_W]),
                .x      (tree_bus[X_OFF +: K + 1]),
                .top    (tree_bus[T_OFF +: K]),
                .bottom (tree_bus[B_OFF +: K])
            );
        end
    end

    // Leftmost leaf in heap order is the topmost element.
    for (genvar c = 0; c < NE; c++) begin : g_leaf
        assign leaf_elem[NE-1-c] = tree_bus[LEAF_OFF + c];
    end

    // Output register, valid pulse and dither LFSR; nodes see the
    // pre-advance LFSR value for the sample being accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            elem       <= '0;
            elem_valid <= 1'b0;
            lfsr       <= LFSR_SEED;
        end else begin
            elem_valid <= sample_valid;
            if (sample_valid) begin
                elem <= leaf_elem;
                lfsr <= lfsr_next(lfsr);
            end
        end
    end

endmodule

// File: doc/smsdac_tree_encoder.md
# smsdac_tree_encoder

Parametrised tree-structured mismatch-shaping encoder for the segmented unit-element DAC. It converts a sampled input code in 0..2^DEPTH into 2^DEPTH registered unit-element enables. It generalises the fixed-size encoder in three ways: tree depth is a parameter, it has a runtime-selectable shaping mode, and it provides LFSR-randomised selection. It sits between the top-level input pins and the DAC element drivers inside the tt_um_* wrapper.

## Interface
- DEPTH, 3: tree levels; element count NE = 2^DEPTH; code width CW = DEPTH+1.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit dither LFSR; must be nonzero.
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- sample_valid  in  1  accept code/mode this cycle.
- code  in  CW  requested element count; values above NE saturate to NE.
- mode  in  2  0 = fixed (no shaping), 1 = first-order shaping, 2 = random (zero-order), 3 = same as 1.
- elem  out  NE  unit-element enables; bit NE-1 is the topmost element.
- elem_valid  out  1  one-cycle pulse marking updated elem.

## Operation
- Binary tree of NE-1 switching blocks. The root node covers elem[NE-1:0], and each node covers a contiguous range. Top child = upper half of the range, bottom child = lower half. Leaf nodes (pairs) drive 2 elem bits directly.
- Node input x (width k+1, range 0..2^k at a node with 2^k elements). The split sign s is in {-1, 0, +1}; top = (x+s)/2 and bottom = (x-s)/2, both exact integers.
- x even: s = 0 in every mode; node state unchanged.
- x odd, per mode:
  - mode 0: s = +1; node state unchanged.
  - mode 1/3: s = +1 if node state = 0, else -1; node state toggles.
  - mode 2: s = +1 if LFSR bit (node_index mod 16) = 1, else -1; node state unchanged.
- Node index is heap order: root 0, children of i are 2i+1 (top) and 2i+2 (bottom).
- LFSR: Fibonacci, taps x^16+x^14+x^13+x^11. It advances once per accepted sample in every mode. Nodes read the pre-advance value.
- Invariant: popcount(elem) = min(code, NE) for every valid output.
- Saturation: code > NE is treated as NE. Its result is all-ones, which is even at every node, so node state is untouched.
- A mode change takes effect on the next accepted sample. Node states and the LFSR are preserved across the change.

## Timing
- Reset values: elem = 0, elem_valid = 0, all node states = 0, LFSR = LFSR_SEED.
- Latency is 1 cycle. A sample accepted at edge n appears on elem and elem_valid at edge n+1.
- The whole tree is combinational within one cycle; there is no pipelining between levels.
- With sample_valid low: elem holds, elem_valid = 0, and node states and the LFSR hold.
- Back-to-back samples are accepted every cycle at full throughput; no backpressure.
- rst_n low mid-stream wins over sample_valid in the same cycle. All state returns to reset values at that edge.
- The first sample after reset is accepted normally.

## Structure
- Package smsdac_pkg holds:
  - mode constants MODE_FIXED = 0, MODE_SHAPE1 = 1, MODE_RAND = 2;
  - LFSR tap mask;
  - a function computing the split for (x, s).
- Sub-module smsdac_switch_block: one tree node containing its state flop and split logic. It is parametrised by the node's level width and instantiated NE-1 times with generate loops.
- The top module owns the LFSR, input saturation, output register and elem_valid.

## Test plan
- Reset: hold rst_n low for 3 cycles while sample_valid = 1 -> elem = 0x00 and elem_valid = 0 throughout.
- Fixed mode, DEPTH = 3:
  - code 1 -> 0x80;
  - code 5 -> 0xEA;
  - code 8 -> 0xFF;
  - code 15 -> 0xFF (saturation);
  - code 0 -> 0x00.
- Mode 1, eight consecutive code 1 samples from reset -> elem sequence 0x80, 0x08, 0x20, 0x02, 0x40, 0x04, 0x10, 0x01, then the sequence repeats.
- Mode 1, gapped sample_valid: code 1, idle 3 cycles, code 1 -> outputs 0x80 then 0x08. elem holds 0x80 during the gap, with elem_valid low.
- Mode 2, 1000 random codes -> popcount(elem) = min(code, 8) for every output. The first output for code 1 matches the reference model seeded with 0xACE1.
- Mid-stream reset during the mode 1 sequence after the 0x08 output, then code 1 -> 0x80, confirming node states were cleared.
